rx_port_buffer_32: RTL and testbench

Receive-side channel buffer for 32-bit RIFFA channels. It sits between the RX engine, which pushes payload words with no backpressure, and the user channel's read interface. Words are stored in a block-RAM FIFO and presented through a prefetch output stage with a valid/enable handshake. The block also tracks a per-transfer word count and flags the last word and transfer completion.

---
 rtl/rx_port_buffer_32_if.sv | 39 +++
 rtl/rx_port_buffer_32.sv | 101 ++++++++++
 tb/tb_rx_port_buffer_32.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rx_port_buffer_32_if.sv
// rx_port_buffer_32_if: bus between a 32-bit RIFFA RX channel buffer and its users.
//   master: the RX engine and user channel. It drives WR_DATA/WR_EN, XFER_START/XFER_LEN and RD_EN.
//   slave:  the buffer. It drives WR_FREE, RD_DATA/RD_VALID/RD_LAST, XFER_COUNT/XFER_DONE.
//   RX_PORT_BUFFER_OVERFLOW_CHK_EN adds the sticky OVERFLOW flag.
interface rx_port_buffer_32_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 512,
  parameter int C_FIFO_DEPTH_WIDTH = $clog2(C_FIFO_DEPTH + 1),
  parameter int C_LEN_WIDTH = 32
);
  logic [C_DATA_WIDTH-1:0] WR_DATA;
  logic WR_EN;
  logic [C_FIFO_DEPTH_WIDTH-1:0] WR_FREE;
  logic XFER_START;
  logic [C_LEN_WIDTH-1:0] XFER_LEN;
  logic [C_DATA_WIDTH-1:0] RD_DATA;
  logic RD_VALID;
  logic RD_EN;
  logic RD_LAST;
  logic [C_LEN_WIDTH-1:0] XFER_COUNT;
  logic XFER_DONE;
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
  logic OVERFLOW;
`endif
  modport master (
    output WR_DATA, WR_EN, XFER_START, XFER_LEN, RD_EN,
    input WR_FREE, RD_DATA, RD_VALID, RD_LAST, XFER_COUNT, XFER_DONE
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
    , OVERFLOW
`endif
  );
  modport slave (
    input WR_DATA, WR_EN, XFER_START, XFER_LEN, RD_EN,
    output WR_FREE, RD_DATA, RD_VALID, RD_LAST, XFER_COUNT, XFER_DONE
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
    , OVERFLOW
`endif
  );
endinterface

// File: rtl/rx_port_buffer_32.sv
// rx_port_buffer_32: RIFFA RX channel buffer with a RAM FIFO, a prefetch output stage and transfer tracking.
//   CLK, RST_N: rising-edge clock and asynchronous active-low reset.
//   bus (slave): writes with no backpressure (WR_DATA/WR_EN) and WR_FREE.
//                Transfer control (XFER_START/XFER_LEN).
//                Read handshake (RD_DATA/RD_VALID/RD_EN/RD_LAST).
//                Progress (XFER_COUNT/XFER_DONE).
//   RX_PORT_BUFFER_OVERFLOW_CHK_EN: when defined, adds OVERFLOW, which is set by a write while WR_FREE==0.
module rx_port_buffer_32 #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 512,
  parameter int C_FIFO_DEPTH_WIDTH = $clog2(C_FIFO_DEPTH + 1),
  parameter int C_LEN_WIDTH = 32
) (
  input logic CLK,
  input logic RST_N,
  rx_port_buffer_32_if.slave bus
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int FW = C_FIFO_DEPTH_WIDTH;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_n;
  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [C_DATA_WIDTH-1:0] in_data, dout, pf0, pf1;
  logic in_vld, dout_vld, acc, cons, iss, rd_valid, rd_last;
  logic [AW-1:0] wptr, rptr;
  logic [FW-1:0] free, ram_cnt;
  logic [1:0] pf_cnt, pf_n, occ;
  logic [C_LEN_WIDTH-1:0] rem, cnt;
  // Occupancy covers the input register, RAM, RAM output and prefetch, so a full count never loses a word.
  assign acc = bus.WR_EN && free != '0;
  assign rd_valid = state == ACTIVE && pf_cnt != 2'd0 && rem != '0;
  assign rd_last = rd_valid && rem == C_LEN_WIDTH'(1);
  assign cons = rd_valid && bus.RD_EN;
  assign occ = pf_cnt + {1'b0, dout_vld};
  // A RAM read is issued only when the RAM output word will have a prefetch slot on the next edge.
  assign iss = ram_cnt != '0 && (occ != 2'd2 || cons);
  assign pf_n = pf_cnt - {1'b0, cons};
  always_ff @(posedge CLK) begin
    if (acc) in_data <= bus.WR_DATA;
    if (in_vld) mem[wptr] <= in_data;
    if (iss) dout <= mem[rptr];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_vld <= 1'b0;
      dout_vld <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      ram_cnt <= '0;
      free <= FW'(C_FIFO_DEPTH);
      pf_cnt <= 2'd0;
      pf0 <= '0;
      pf1 <= '0;
    end else begin
      in_vld <= acc;
      dout_vld <= iss;
      if (in_vld) wptr <= wptr + AW'(1);
      if (iss) rptr <= rptr + AW'(1);
      ram_cnt <= ram_cnt + FW'(in_vld) - FW'(iss);
      free <= free - FW'(acc) + FW'(cons);
      pf_cnt <= pf_n + {1'b0, dout_vld};
      if (cons) pf0 <= pf1;
      if (dout_vld && pf_n == 2'd0) pf0 <= dout;
      if (dout_vld && pf_n == 2'd1) pf1 <= dout;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (bus.XFER_START ? (bus.XFER_LEN == '0 ? DONE : ACTIVE) : IDLE)
            : state == ACTIVE ? (cons && rd_last ? DONE : ACTIVE) : IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.XFER_START) begin
        rem <= bus.XFER_LEN;
        cnt <= '0;
      end else if (cons) begin
        rem <= rem - C_LEN_WIDTH'(1);
        cnt <= cnt + C_LEN_WIDTH'(1);
      end
    end
  end
  assign bus.WR_FREE = free;
  assign bus.RD_DATA = pf0;
  assign bus.RD_VALID = rd_valid;
  assign bus.RD_LAST = rd_last;
  assign bus.XFER_COUNT = cnt;
  assign bus.XFER_DONE = state == DONE;
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
  logic ovf;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf <= 1'b0;
    else if (bus.WR_EN && free == '0) ovf <= 1'b1;
  end
  assign bus.OVERFLOW = ovf;
`endif
endmodule

// File: tb/tb_rx_port_buffer_32.sv
// tb_rx_port_buffer_32: directed and random checks of rx_port_buffer_32 against a queue-based reference model.
module tb_rx_port_buffer_32;
  localparam int DEPTH = 512;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rx_port_buffer_32_if bus();
  rx_port_buffer_32 dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [31:0] mq[$];
  int mt[$];
  int now = 0;
  int mst = 0;
  longint mrem = 0;
  longint mcnt = 0;
  bit movf = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // A word is deliverable once at least three edges have passed since the edge that wrote it.
  function automatic bit m_valid();
    return mst == 1 && mq.size() > 0 && mrem != 0 && mt[0] + 3 <= now;
  endfunction
  task automatic chk_rst(input string tag);
    chk({tag, "_rd_valid"}, bus.RD_VALID, 0);
    chk({tag, "_rd_last"}, bus.RD_LAST, 0);
    chk({tag, "_rd_data"}, bus.RD_DATA, 0);
    chk({tag, "_xfer_count"}, bus.XFER_COUNT, 0);
    chk({tag, "_xfer_done"}, bus.XFER_DONE, 0);
    chk({tag, "_wr_free"}, bus.WR_FREE, DEPTH);
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
    chk({tag, "_overflow"}, bus.OVERFLOW, 0);
`endif
  endtask
  task automatic m_reset();
    mq.delete();
    mt.delete();
    mst = 0;
    mrem = 0;
    mcnt = 0;
    movf = 1'b0;
  endtask
  task automatic cyc();
    bit v, cons, acc, st;
    logic [31:0] wd, len;
    v = m_valid();
    chk("rd_valid", bus.RD_VALID, v);
    if (v) chk("rd_data", bus.RD_DATA, mq[0]);
    chk("rd_last", bus.RD_LAST, v && mrem == 1);
    chk("xfer_done", bus.XFER_DONE, mst == 2);
    chk("xfer_count", bus.XFER_COUNT, mcnt);
    chk("wr_free", bus.WR_FREE, DEPTH - mq.size());
`ifdef RX_PORT_BUFFER_OVERFLOW_CHK_EN
    chk("overflow", bus.OVERFLOW, movf);
`endif
    cons = v && bus.RD_EN;
    acc = bus.WR_EN && mq.size() < DEPTH;
    if (bus.WR_EN && !acc) movf = 1'b1;
    st = bus.XFER_START;
    len = bus.XFER_LEN;
    wd = bus.WR_DATA;
    @(posedge clk);
    now++;
    if (cons) begin
      void'(mq.pop_front());
      void'(mt.pop_front());
      mrem--;
      mcnt++;
    end
    if (acc) begin
      mq.push_back(wd);
      mt.push_back(now);
    end
    if (mst == 0 && st) begin
      mcnt = 0;
      mrem = len;
      mst = len == 0 ? 2 : 1;
    end else if (mst == 1) mst = cons && mrem == 0 ? 2 : 1;
    else if (mst == 2) mst = 0;
    @(negedge clk);
  endtask
  task automatic cy(input bit we, input logic [31:0] wd, input bit re, input bit st = 1'b0, input logic [31:0] len = 0);
    bus.WR_EN = we;
    bus.WR_DATA = wd;
    bus.RD_EN = re;
    bus.XFER_START = st;
    bus.XFER_LEN = len;
    cyc();
  endtask
  task automatic wait_done(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      cy(0, 0, 1);
      seen = bus.XFER_DONE;
    end
    chk({tag, "_done_seen"}, seen, 1);
    cy(0, 0, 1);
  endtask
  initial begin
    bus.WR_EN = 0;
    bus.WR_DATA = 0;
    bus.RD_EN = 0;
    bus.XFER_START = 0;
    bus.XFER_LEN = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cy(1, i, 0);
    cy(0, 0, 1, 1, 4);
    wait_done("four", 10);
    chk("four_count", bus.XFER_COUNT, 4);
    cy(0, 0, 0, 1, 2);
    cy(1, 32'hA5A5_0001, 0);
    for (int i = 0; i < 8; i++) cy(0, 0, 0);
    cy(1, 32'hA5A5_0002, 1);
    wait_done("latency", 10);
    for (int i = 0; i < 6; i++) cy(1, 32'h100 + i, 0);
    cy(0, 0, 1, 1, 4);
    wait_done("six_first", 12);
    chk("six_free", bus.WR_FREE, DEPTH - 2);
    cy(0, 0, 1, 1, 2);
    wait_done("six_second", 8);
    for (int i = 0; i < DEPTH; i++) cy(1, 32'h5000 + i, 0);
    chk("full_free", bus.WR_FREE, 0);
    cy(1, 32'hDEAD_BEEF, 0);
    chk("full_free_after_drop", bus.WR_FREE, 0);
    cy(0, 0, 1, 1, DEPTH);
    wait_done("full", DEPTH + 10);
    chk("full_count", bus.XFER_COUNT, DEPTH);
    cy(0, 0, 1, 1, 0);
    chk("len0_done", bus.XFER_DONE, 1);
    cy(0, 0, 1);
    chk("len0_count", bus.XFER_COUNT, 0);
    for (int i = 0; i < 8; i++) cy(1, 32'h700 + i, 0);
    cy(0, 0, 1, 1, 8);
    for (int i = 0; i < 20 && mcnt < 3; i++) cy(0, 0, 1);
    chk("mid_consumed", bus.XFER_COUNT, 3);
    rst_n = 1'b0;
    #1;
    chk_rst("mid_reset");
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cy(0, 0, 1);
    chk("post_reset_free", bus.WR_FREE, DEPTH);
    for (int i = 0; i < 4000; i++)
      cy($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 12));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
